// File: rtl/stage_mem.sv
// stage_mem: memory-access pipeline stage between EX and WB with a handshaked data port.
// Define MEM_MISALIGN_CHK_EN to trap misaligned halfword/word accesses instead of performing them.
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif
`ifndef MEM_ADDR_WIDTH
`define MEM_ADDR_WIDTH 32
`endif
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

module stage_mem #(
    parameter int reg_addr_width = `REG_ADDR_WIDTH,
    parameter int ins_addr_width = `MEM_ADDR_WIDTH,
    parameter int word_width     = `WORD_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [ins_addr_width-1:0] tgt_addr_in,
    input  logic [word_width-1:0]     rslt_in,
    input  logic [word_width-1:0]     rs2_val_in,
    input  logic [word_width-1:0]     imm_ext_in,
    input  logic [reg_addr_width-1:0] rd_addr_in,
    input  logic                      jmp_ctl_in,
    input  logic                      bch_ctl_in,
    input  logic                      mem_ctl_in,
    input  logic                      rd_wen_in,
    input  logic [1:0]                wb_ctl_in,
    input  logic [2:0]                byt_typ_in,
    input  logic [word_width-1:0]     dmem_rdata,
    input  logic                      dmem_ack,
    output logic                      dmem_req,
    output logic                      dmem_we,
    output logic [word_width-1:0]     dmem_addr,
    output logic [word_width-1:0]     dmem_wdata,
    output logic [3:0]                dmem_be,
    output logic                      stall,
    output logic                      redirect,
    output logic [ins_addr_width-1:0] redirect_addr,
    output logic                      mem_wen,
    output logic [reg_addr_width-1:0] mem_rd,
    output logic [word_width-1:0]     mem_d,
    output logic                      rd_wen_out,
    output logic [reg_addr_width-1:0] rd_addr_out,
    output logic [1:0]                wb_ctl_out,
    output logic [word_width-1:0]     rslt_out,
    output logic [word_width-1:0]     ld_data_out,
    output logic [word_width-1:0]     imm_ext_out,
    output logic                      misalign_err
);

    typedef enum logic [0:0] {IDLE = 1'b0, WAIT = 1'b1} state_t;

    state_t                    state_q, state_d;
    logic [ins_addr_width-1:0] tgt_addr_q, tgt_addr_d;
    logic [word_width-1:0]     rslt_q, rslt_d, rs2_val_q, rs2_val_d, imm_ext_q, imm_ext_d;
    logic [reg_addr_width-1:0] rd_addr_q, rd_addr_d;
    logic                      jmp_ctl_q, jmp_ctl_d, bch_ctl_q, bch_ctl_d;
    logic                      mem_ctl_q, mem_ctl_d, rd_wen_q, rd_wen_d;
    logic [1:0]                wb_ctl_q, wb_ctl_d;
    logic [2:0]                byt_typ_q, byt_typ_d;

    logic                      is_load_s, mem_op_s, misalign_s;
    logic [3:0]                be_s;
    logic [word_width-1:0]     wdata_s, lane_s;

    // Pipeline capture: load from EX unless the stage is stalled.
    always_comb begin
        tgt_addr_d = tgt_addr_q;
        rslt_d     = rslt_q;
        rs2_val_d  = rs2_val_q;
        imm_ext_d  = imm_ext_q;
        rd_addr_d  = rd_addr_q;
        jmp_ctl_d  = jmp_ctl_q;
        bch_ctl_d  = bch_ctl_q;
        mem_ctl_d  = mem_ctl_q;
        rd_wen_d   = rd_wen_q;
        wb_ctl_d   = wb_ctl_q;
        byt_typ_d  = byt_typ_q;
        if (stall) begin
            rslt_d = rslt_q;
        end else begin
            tgt_addr_d = tgt_addr_in;
            rslt_d     = rslt_in;
            rs2_val_d  = rs2_val_in;
            imm_ext_d  = imm_ext_in;
            rd_addr_d  = rd_addr_in;
            jmp_ctl_d  = jmp_ctl_in;
            bch_ctl_d  = bch_ctl_in;
            mem_ctl_d  = mem_ctl_in;
            rd_wen_d   = rd_wen_in;
            wb_ctl_d   = wb_ctl_in;
            byt_typ_d  = byt_typ_in;
        end
    end

    // State and pipeline registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            tgt_addr_q <= '0;
            rslt_q     <= '0;
            rs2_val_q  <= '0;
            imm_ext_q  <= '0;
            rd_addr_q  <= '0;
            jmp_ctl_q  <= 1'b0;
            bch_ctl_q  <= 1'b0;
            mem_ctl_q  <= 1'b0;
            rd_wen_q   <= 1'b0;
            wb_ctl_q   <= 2'b00;
            byt_typ_q  <= 3'b000;
        end else begin
            state_q    <= state_d;
            tgt_addr_q <= tgt_addr_d;
            rslt_q     <= rslt_d;
            rs2_val_q  <= rs2_val_d;
            imm_ext_q  <= imm_ext_d;
            rd_addr_q  <= rd_addr_d;
            jmp_ctl_q  <= jmp_ctl_d;
            bch_ctl_q  <= bch_ctl_d;
            mem_ctl_q  <= mem_ctl_d;
            rd_wen_q   <= rd_wen_d;
            wb_ctl_q   <= wb_ctl_d;
            byt_typ_q  <= byt_typ_d;
        end
    end

    // Access classification; byt_typ[1:0] of 10/11 are both treated as word size.
    always_comb begin
        is_load_s  = (wb_ctl_q == 2'b01);
        mem_op_s   = is_load_s | mem_ctl_q;
        misalign_s = 1'b0;
`ifdef MEM_MISALIGN_CHK_EN
        case (byt_typ_q[1:0])
            2'b00:   misalign_s = 1'b0;
            2'b01:   misalign_s = mem_op_s & rslt_q[0];
            default: misalign_s = mem_op_s & (rslt_q[1:0] != 2'b00);
        endcase
`endif
    end

    // Handshake FSM; the request itself is level-driven by the latched operation.
    always_comb begin
        state_d  = state_q;
        dmem_req = mem_op_s & ~misalign_s;
        stall    = dmem_req & ~dmem_ack;
        case (state_q)
            IDLE:    state_d = (dmem_req & ~dmem_ack) ? WAIT : IDLE;
            WAIT:    state_d = dmem_ack ? IDLE : WAIT;
            default: state_d = IDLE;
        endcase
    end

    // Store lane enables and replicated write data.
    always_comb begin
        be_s    = 4'b1111;
        wdata_s = rs2_val_q;
        case (byt_typ_q[1:0])
            2'b00: begin
                be_s    = 4'b0001 << rslt_q[1:0];
                wdata_s = {(word_width / 8){rs2_val_q[7:0]}};
            end
            2'b01: begin
                be_s    = 4'b0011 << rslt_q[1:0];
                wdata_s = {(word_width / 16){rs2_val_q[15:0]}};
            end
            default: begin
                be_s    = 4'b1111;
                wdata_s = rs2_val_q;
            end
        endcase
    end

    // Load lane extraction and extension.
    always_comb begin
        lane_s = dmem_rdata >> {rslt_q[1:0], 3'b000};
        case (byt_typ_q)
            3'b000:  ld_data_out = {{(word_width - 8){lane_s[7]}}, lane_s[7:0]};
            3'b001:  ld_data_out = {{(word_width - 16){lane_s[15]}}, lane_s[15:0]};
            3'b100:  ld_data_out = {{(word_width - 8){1'b0}}, lane_s[7:0]};
            3'b101:  ld_data_out = {{(word_width - 16){1'b0}}, lane_s[15:0]};
            default: ld_data_out = dmem_rdata;
        endcase
    end

    // Memory port, forwarding, writeback and redirect outputs.
    always_comb begin
        dmem_we       = mem_ctl_q;
        dmem_addr     = {rslt_q[word_width-1:2], 2'b00};
        dmem_be       = mem_ctl_q ? be_s : 4'b0000;
        dmem_wdata    = wdata_s;
        misalign_err  = misalign_s;
        rd_wen_out    = rd_wen_q & ~stall & ~misalign_s;
        mem_wen       = rd_wen_q & ~stall & ~misalign_s & ~is_load_s;
        mem_rd        = rd_addr_q;
        mem_d         = (wb_ctl_q == 2'b10) ? imm_ext_q : rslt_q;
        rd_addr_out   = rd_addr_q;
        wb_ctl_out    = wb_ctl_q;
        rslt_out      = rslt_q;
        imm_ext_out   = imm_ext_q;
        redirect      = jmp_ctl_q | (bch_ctl_q & rslt_q[0]);
        redirect_addr = tgt_addr_q;
    end

endmodule

// File: tb/tb_stage_mem.sv
// tb_stage_mem: vector table with scoreboard queue plus directed wait-state, reset and misalign sequences.
module tb_stage_mem;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] tgt_addr_in, rslt_in, rs2_val_in, imm_ext_in, dmem_rdata;
    logic [4:0]  rd_addr_in;
    logic        jmp_ctl_in, bch_ctl_in, mem_ctl_in, rd_wen_in, dmem_ack;
    logic [1:0]  wb_ctl_in;
    logic [2:0]  byt_typ_in;
    logic        dmem_req, dmem_we, stall, redirect, mem_wen, rd_wen_out, misalign_err;
    logic [31:0] dmem_addr, dmem_wdata, redirect_addr, mem_d, rslt_out, ld_data_out, imm_ext_out;
    logic [3:0]  dmem_be;
    logic [4:0]  mem_rd, rd_addr_out;
    logic [1:0]  wb_ctl_out;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0] rslt, rs2, imm, tgt, rdata;
        logic [4:0]  rd;
        logic        jmp, bch, mem, rdwen;
        logic [1:0]  wb;
        logic [2:0]  byt;
    } in_t;

    typedef struct {
        logic        req, we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata, ld;
        logic        redir, rdwen, memwen;
        logic [31:0] memd;
    } exp_t;

    typedef struct {
        in_t  i;
        exp_t e;
    } vec_t;

    localparam int NV = 17;
    vec_t tbl [NV];
    vec_t sb [$];
    vec_t cur;
    in_t  nop;

    stage_mem dut (
        .clk(clk), .rst_n(rst_n),
        .tgt_addr_in(tgt_addr_in), .rslt_in(rslt_in), .rs2_val_in(rs2_val_in),
        .imm_ext_in(imm_ext_in), .rd_addr_in(rd_addr_in),
        .jmp_ctl_in(jmp_ctl_in), .bch_ctl_in(bch_ctl_in), .mem_ctl_in(mem_ctl_in),
        .rd_wen_in(rd_wen_in), .wb_ctl_in(wb_ctl_in), .byt_typ_in(byt_typ_in),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .stall(stall),
        .redirect(redirect), .redirect_addr(redirect_addr),
        .mem_wen(mem_wen), .mem_rd(mem_rd), .mem_d(mem_d),
        .rd_wen_out(rd_wen_out), .rd_addr_out(rd_addr_out), .wb_ctl_out(wb_ctl_out),
        .rslt_out(rslt_out), .ld_data_out(ld_data_out), .imm_ext_out(imm_ext_out),
        .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input in_t v);
        rslt_in    = v.rslt;
        rs2_val_in = v.rs2;
        imm_ext_in = v.imm;
        tgt_addr_in = v.tgt;
        rd_addr_in = v.rd;
        jmp_ctl_in = v.jmp;
        bch_ctl_in = v.bch;
        mem_ctl_in = v.mem;
        rd_wen_in  = v.rdwen;
        wb_ctl_in  = v.wb;
        byt_typ_in = v.byt;
    endtask

    task automatic check_out(input int k, input vec_t v);
        chk($sformatf("v%0d.req", k), 32'(dmem_req), 32'(v.e.req));
        chk($sformatf("v%0d.we", k), 32'(dmem_we), 32'(v.e.we));
        chk($sformatf("v%0d.addr", k), dmem_addr, v.e.addr);
        chk($sformatf("v%0d.stall", k), 32'(stall), 32'h0);
        if (v.i.mem) begin
            chk($sformatf("v%0d.be", k), 32'(dmem_be), 32'(v.e.be));
            chk($sformatf("v%0d.wdata", k), dmem_wdata, v.e.wdata);
        end
        if (v.i.wb == 2'b01) begin
            chk($sformatf("v%0d.ld", k), ld_data_out, v.e.ld);
        end
        chk($sformatf("v%0d.redir", k), 32'(redirect), 32'(v.e.redir));
        chk($sformatf("v%0d.raddr", k), redirect_addr, v.i.tgt);
        chk($sformatf("v%0d.rdwen", k), 32'(rd_wen_out), 32'(v.e.rdwen));
        chk($sformatf("v%0d.memwen", k), 32'(mem_wen), 32'(v.e.memwen));
        chk($sformatf("v%0d.memd", k), mem_d, v.e.memd);
        chk($sformatf("v%0d.memrd", k), 32'(mem_rd), 32'(v.i.rd));
        chk($sformatf("v%0d.rdaddr", k), 32'(rd_addr_out), 32'(v.i.rd));
        chk($sformatf("v%0d.wbctl", k), 32'(wb_ctl_out), 32'(v.i.wb));
        chk($sformatf("v%0d.rslt", k), rslt_out, v.i.rslt);
        chk($sformatf("v%0d.imm", k), imm_ext_out, v.i.imm);
        chk($sformatf("v%0d.mis", k), 32'(misalign_err), 32'h0);
    endtask

    initial begin
        int stall_cnt;
        int pulse_cnt;
        in_t tmp;

        //            rslt          rs2           imm           tgt          rdata         rd     jmp   bch   mem   rdwen wb     byt
        tbl[0]  = '{'{32'h100, 32'hDEADBEEF, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 3'b010},
                    '{1'b1, 1'b1, 32'h100, 4'b1111, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0, 1'b0, 32'h100}};
        tbl[1]  = '{'{32'h101, 32'h123456AB, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 3'b000},
                    '{1'b1, 1'b1, 32'h100, 4'b0010, 32'hABABABAB, 32'h0, 1'b0, 1'b0, 1'b0, 32'h101}};
        tbl[2]  = '{'{32'h202, 32'h0000BEEF, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 3'b001},
                    '{1'b1, 1'b1, 32'h200, 4'b1100, 32'hBEEFBEEF, 32'h0, 1'b0, 1'b0, 1'b0, 32'h202}};
        tbl[3]  = '{'{32'h300, 32'h01020304, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 3'b110},
                    '{1'b1, 1'b1, 32'h300, 4'b1111, 32'h01020304, 32'h0, 1'b0, 1'b0, 1'b0, 32'h300}};
        tbl[4]  = '{'{32'h103, 32'h0, 32'h0, 32'h0, 32'h80FFFFFF, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 3'b000},
                    '{1'b1, 1'b0, 32'h100, 4'b0000, 32'h0, 32'hFFFFFF80, 1'b0, 1'b1, 1'b0, 32'h103}};
        tbl[5]  = '{'{32'h102, 32'h0, 32'h0, 32'h0, 32'h80010000, 5'd6, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 3'b101},
                    '{1'b1, 1'b0, 32'h100, 4'b0000, 32'h0, 32'h00008001, 1'b0, 1'b1, 1'b0, 32'h102}};
        tbl[6]  = '{'{32'h102, 32'h0, 32'h0, 32'h0, 32'h80010000, 5'd7, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 3'b001},
                    '{1'b1, 1'b0, 32'h100, 4'b0000, 32'h0, 32'hFFFF8001, 1'b0, 1'b1, 1'b0, 32'h102}};
        tbl[7]  = '{'{32'h101, 32'h0, 32'h0, 32'h0, 32'h0000A500, 5'd8, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 3'b100},
                    '{1'b1, 1'b0, 32'h100, 4'b0000, 32'h0, 32'h000000A5, 1'b0, 1'b1, 1'b0, 32'h101}};
        tbl[8]  = '{'{32'h104, 32'h0, 32'h0, 32'h0, 32'hCAFEF00D, 5'd9, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 3'b010},
                    '{1'b1, 1'b0, 32'h104, 4'b0000, 32'h0, 32'hCAFEF00D, 1'b0, 1'b1, 1'b0, 32'h104}};
        tbl[9]  = '{'{32'h108, 32'h0, 32'h0, 32'h0, 32'h11223344, 5'd10, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 3'b111},
                    '{1'b1, 1'b0, 32'h108, 4'b0000, 32'h0, 32'h11223344, 1'b0, 1'b1, 1'b0, 32'h108}};
        tbl[10] = '{'{32'h200, 32'h0, 32'h0, 32'h0, 32'h0000007F, 5'd11, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 3'b000},
                    '{1'b1, 1'b0, 32'h200, 4'b0000, 32'h0, 32'h0000007F, 1'b0, 1'b1, 1'b0, 32'h200}};
        tbl[11] = '{'{32'h200, 32'h0, 32'h0, 32'h0, 32'h1234F00F, 5'd12, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 3'b001},
                    '{1'b1, 1'b0, 32'h200, 4'b0000, 32'h0, 32'hFFFFF00F, 1'b0, 1'b1, 1'b0, 32'h200}};
        tbl[12] = '{'{32'h55, 32'h0, 32'h0, 32'h0, 32'h0, 5'd13, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 3'b000},
                    '{1'b0, 1'b0, 32'h54, 4'b0000, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h55}};
        tbl[13] = '{'{32'h7, 32'h0, 32'hABCD0000, 32'h0, 32'h0, 5'd14, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 3'b000},
                    '{1'b0, 1'b0, 32'h4, 4'b0000, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 32'hABCD0000}};
        tbl[14] = '{'{32'h1, 32'h0, 32'h0, 32'h40, 32'h0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 3'b000},
                    '{1'b0, 1'b0, 32'h0, 4'b0000, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h1}};
        tbl[15] = '{'{32'h0, 32'h0, 32'h0, 32'h40, 32'h0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 3'b000},
                    '{1'b0, 1'b0, 32'h0, 4'b0000, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0}};
        tbl[16] = '{'{32'h0, 32'h0, 32'h0, 32'h80, 32'h0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000},
                    '{1'b0, 1'b0, 32'h0, 4'b0000, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0}};

        nop = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000};

        // Reset state
        rst_n = 1'b0;
        dmem_ack = 1'b0;
        dmem_rdata = 32'h0;
        drive(nop);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.req", 32'(dmem_req), 32'h0);
        chk("rst.stall", 32'(stall), 32'h0);
        chk("rst.redir", 32'(redirect), 32'h0);
        chk("rst.rdwen", 32'(rd_wen_out), 32'h0);
        chk("rst.memwen", 32'(mem_wen), 32'h0);
        chk("rst.mis", 32'(misalign_err), 32'h0);
        rst_n = 1'b1;

        // Table: zero-wait memory, expected pushed at drive and popped one cycle later
        dmem_ack = 1'b1;
        for (int k = 0; k < NV; k++) begin
            drive(tbl[k].i);
            sb.push_back(tbl[k]);
            @(posedge clk);
            #1;
            dmem_rdata = tbl[k].i.rdata;
            @(negedge clk);
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL sb_empty: got 0 entries expected 1");
            end else begin
                cur = sb.pop_front();
                check_out(k, cur);
            end
        end

        // LB with three wait states: stage holds, writeback fires once
        drive(tbl[4].i);
        @(posedge clk);
        #1;
        dmem_ack = 1'b0;
        dmem_rdata = 32'h80FFFFFF;
        tmp = '{32'h66, 32'h0, 32'h0, 32'h0, 32'h0, 5'd9, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 3'b000};
        drive(tmp);
        stall_cnt = 0;
        pulse_cnt = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (stall) begin
                stall_cnt++;
                chk("wait.hold_rd", 32'(rd_addr_out), 32'd5);
            end else begin
                stall_cnt = stall_cnt;
            end
            if (rd_wen_out) begin
                pulse_cnt++;
                chk("wait.ld", ld_data_out, 32'hFFFFFF80);
            end else begin
                pulse_cnt = pulse_cnt;
            end
            if (!stall) break;
            @(posedge clk);
            #1;
            if (c == 2) dmem_ack = 1'b1;
        end
        chk("wait.stall_cycles", 32'(stall_cnt), 32'd3);
        chk("wait.rdwen_pulses", 32'(pulse_cnt), 32'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("wait.next_rd", 32'(rd_addr_out), 32'd9);
        chk("wait.next_rslt", rslt_out, 32'h66);
        chk("wait.next_req", 32'(dmem_req), 32'h0);

        // Reset while waiting: request drops at once, late ack ignored
        drive(tbl[0].i);
        @(posedge clk);
        #1;
        dmem_ack = 1'b0;
        drive(nop);
        @(negedge clk);
        chk("rstw.pre_stall", 32'(stall), 32'h1);
        chk("rstw.pre_req", 32'(dmem_req), 32'h1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rstw.req", 32'(dmem_req), 32'h0);
        chk("rstw.stall", 32'(stall), 32'h0);
        chk("rstw.we", 32'(dmem_we), 32'h0);
        @(posedge clk);
        #1;
        dmem_ack = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rstw.late_req", 32'(dmem_req), 32'h0);
        chk("rstw.late_stall", 32'(stall), 32'h0);
        chk("rstw.late_rdwen", 32'(rd_wen_out), 32'h0);

        // Misaligned word store and word load
        tmp = '{32'h102, 32'hA5A5A5A5, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 3'b010};
        drive(tmp);
        @(posedge clk);
        #1;
        tmp = '{32'h101, 32'h0, 32'h0, 32'h0, 32'h0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 3'b010};
        drive(tmp);
        @(negedge clk);
`ifdef MEM_MISALIGN_CHK_EN
        chk("mis.sw_err", 32'(misalign_err), 32'h1);
        chk("mis.sw_req", 32'(dmem_req), 32'h0);
        chk("mis.sw_stall", 32'(stall), 32'h0);
`else
        chk("mis.sw_err", 32'(misalign_err), 32'h0);
        chk("mis.sw_req", 32'(dmem_req), 32'h1);
        chk("mis.sw_be", 32'(dmem_be), 32'hF);
        chk("mis.sw_addr", dmem_addr, 32'h100);
`endif
        @(posedge clk);
        #1;
        drive(nop);
        @(negedge clk);
`ifdef MEM_MISALIGN_CHK_EN
        chk("mis.lw_err", 32'(misalign_err), 32'h1);
        chk("mis.lw_rdwen", 32'(rd_wen_out), 32'h0);
        chk("mis.lw_memwen", 32'(mem_wen), 32'h0);
`else
        chk("mis.lw_err", 32'(misalign_err), 32'h0);
        chk("mis.lw_rdwen", 32'(rd_wen_out), 32'h1);
        chk("mis.lw_addr", dmem_addr, 32'h100);
`endif
        @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
